// File: rtl/spi_conf_rx_pkg.sv
// Shared command encoding and frame geometry for the SPI configuration receiver.
// The ARM-side header generator mirrors these constants.
package spi_conf_rx_pkg;

    localparam int WORD_W = 16;
    localparam int CMD_W  = 4;
    localparam int CNT_W  = $clog2(WORD_W + 2);

    localparam logic [CMD_W-1:0] CMD_SET_CONF = 4'h1;
    localparam logic [CMD_W-1:0] CMD_SET_DIV  = 4'h2;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    function automatic logic [CMD_W-1:0] cmd_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: CMD_W];
    endfunction

endpackage

// File: rtl/spi_conf_rx_if.sv
// SPI pin bundle between the ARM (master) and the FPGA configuration receiver (slave).
interface spi_conf_rx_if;

    logic ncs;
    logic spcki;
    logic mosi;
    logic miso;

    modport master (output ncs, output spcki, output mosi, input miso);
    modport slave  (input ncs, input spcki, input mosi, output miso);

endinterface

// File: rtl/spi_conf_rx_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses taken
// against one extra delay flop behind the synchronised level.
module spi_conf_rx_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              q_d_reg;

    // Everything resets low so a pin that is held low across reset produces no edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_reg <= '0;
            q_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
            q_d_reg  <= sync_reg[STAGES-1];
        end
    end

    assign q    = sync_reg[STAGES-1];
    assign rise =  q & ~q_d_reg;
    assign fall = ~q &  q_d_reg;

endmodule

// File: rtl/spi_conf_rx.sv
// SPI-slave command receiver: collects 16-bit words from the ARM, decodes them into the
// mode/divider configuration registers and echoes the last accepted word on miso.
module spi_conf_rx
    import spi_conf_rx_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DIV_RST     = 8'h5F
) (
    input  logic          ck_1356meg,
    input  logic          nrst,
    spi_conf_rx_if.slave  spi,
    output logic [7:0]    conf_reg,
    output logic [7:0]    divisor,
    output logic          word_valid,
    output logic          frame_err
);

    logic ncs_s, ncs_rise, ncs_fall;
    logic spcki_s, spcki_rise, spcki_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic mosi_s;

    spi_conf_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk  (ck_1356meg),
        .nrst (nrst),
        .d    (spi.ncs),
        .q    (ncs_s),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    spi_conf_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_spcki_sync (
        .clk  (ck_1356meg),
        .nrst (nrst),
        .d    (spi.spcki),
        .q    (spcki_s),
        .rise (spcki_rise),
        .fall (spcki_fall)
    );

    // Only edges of spcki matter; its synchronised level is not needed.
    logic unused_spcki_level;
    assign unused_spcki_level = spcki_s;

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            mosi_sync_reg <= '0;
        end else begin
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi.mosi};
        end
    end
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    state_t            state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [WORD_W-1:0] shift_in_reg;
    logic [WORD_W-1:0] shift_out_reg;
    logic [WORD_W-1:0] echo_reg;
    logic              eval_pending_reg;
    logic              miso_reg;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state_reg        <= WAIT_IDLE;
            bit_cnt_reg      <= '0;
            shift_in_reg     <= '0;
            shift_out_reg    <= '0;
            echo_reg         <= '0;
            eval_pending_reg <= 1'b0;
            miso_reg         <= 1'b0;
            conf_reg         <= 8'h00;
            divisor          <= DIV_RST;
            word_valid       <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            word_valid       <= 1'b0;
            frame_err        <= 1'b0;
            eval_pending_reg <= 1'b0;

            // Judged one cycle after the ncs rise, using the frame's final counters.
            if (eval_pending_reg) begin
                if (bit_cnt_reg == CNT_FULL) begin
                    word_valid <= 1'b1;
                    echo_reg   <= shift_in_reg;
                    case (cmd_of(shift_in_reg))
                        CMD_SET_CONF: conf_reg <= shift_in_reg[7:0];
                        CMD_SET_DIV:  divisor  <= shift_in_reg[7:0];
                        default:      ;
                    endcase
                end else begin
                    frame_err <= 1'b1;
                end
            end

            case (state_reg)
                WAIT_IDLE: begin
                    // Swallow any frame already in progress when reset was released.
                    if (ncs_s) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (ncs_fall) begin
                        state_reg     <= SHIFT;
                        bit_cnt_reg   <= '0;
                        shift_out_reg <= echo_reg;
                        miso_reg      <= echo_reg[WORD_W-1];
                    end
                end
                SHIFT: begin
                    // ncs is checked first so a coincident spcki edge is dropped.
                    if (ncs_rise) begin
                        state_reg        <= IDLE;
                        eval_pending_reg <= 1'b1;
                    end else if (spcki_rise) begin
                        shift_in_reg <= {shift_in_reg[WORD_W-2:0], mosi_s};
                        if (bit_cnt_reg != CNT_SAT) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (spcki_fall) begin
                        shift_out_reg <= {shift_out_reg[WORD_W-2:0], 1'b0};
                        miso_reg      <= shift_out_reg[WORD_W-2];
                    end
                end
                default: state_reg <= WAIT_IDLE;
            endcase
        end
    end

    assign spi.miso = miso_reg;

endmodule
